exec_ctrl_pipe: RTL and testbench

Execute-side control pipeline for the pipelined ARM core. Captures the control word produced by the decode-stage controller, evaluates the instruction's condition field against the NZCV flags register, and gates architectural side effects. It then carries surviving controls through the Memory and Writeback pipeline registers. It sits directly downstream of the decode controller and feeds the datapath ALU/mux selects, the branch/PC logic and the hazard unit.

---
 rtl/exec_ctrl_pipe_if.sv | 60 ++++++
 rtl/exec_ctrl_pipe.sv | 157 +++++++++++++++
 tb/tb_exec_ctrl_pipe.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/exec_ctrl_pipe_if.sv
// -----------------------------------------------------------------------------
// exec_ctrl_pipe_if
// Bundles the control bus between the decode controller, the execute-side
// control pipeline and its consumers (datapath, branch/PC logic, hazard unit).
//
// Signals (direction as seen by the pipeline, i.e. the slave modport):
//   FlushE        in   hazard unit bubble request for the E register
//   PCSrcD .. CondD   in   decode-stage control word
//   ALUFlags      in   {N,Z,C,V} produced by the ALU in E
//   ALUControlE, ALUSrcE, MemtoRegE, BranchTakenE   out  E-stage controls
//   PCSrcM, RegWriteM, MemtoRegM, MemWriteM         out  M-stage controls
//   PCSrcW, RegWriteW, MemtoRegW                    out  W-stage controls
//   FlagsQ        out  current NZCV register
//
// Modports:
//   master - the environment (drives decode controls, observes outputs)
//   slave  - exec_ctrl_pipe itself
// -----------------------------------------------------------------------------
interface exec_ctrl_pipe_if;
  logic       FlushE;
  logic       PCSrcD;
  logic       RegWriteD;
  logic       MemtoRegD;
  logic       MemWriteD;
  logic       BranchD;
  logic [1:0] ALUControlD;
  logic [1:0] ALUSrcD;
  logic [1:0] FlagWriteD;
  logic [3:0] CondD;
  logic [3:0] ALUFlags;

  logic [1:0] ALUControlE;
  logic [1:0] ALUSrcE;
  logic       MemtoRegE;
  logic       BranchTakenE;
  logic       PCSrcM;
  logic       RegWriteM;
  logic       MemtoRegM;
  logic       MemWriteM;
  logic       PCSrcW;
  logic       RegWriteW;
  logic       MemtoRegW;
  logic [3:0] FlagsQ;

  modport master (
    output FlushE, PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD,
           ALUControlD, ALUSrcD, FlagWriteD, CondD, ALUFlags,
    input  ALUControlE, ALUSrcE, MemtoRegE, BranchTakenE,
           PCSrcM, RegWriteM, MemtoRegM, MemWriteM,
           PCSrcW, RegWriteW, MemtoRegW, FlagsQ
  );

  modport slave (
    input  FlushE, PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD,
           ALUControlD, ALUSrcD, FlagWriteD, CondD, ALUFlags,
    output ALUControlE, ALUSrcE, MemtoRegE, BranchTakenE,
           PCSrcM, RegWriteM, MemtoRegM, MemWriteM,
           PCSrcW, RegWriteW, MemtoRegW, FlagsQ
  );
endinterface

// File: rtl/exec_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// exec_ctrl_pipe
// Execute-side control pipeline of the pipelined ARM core. Registers the
// decode control word into E, evaluates the ARM condition field against the
// NZCV register, suppresses side effects of failed instructions and carries
// the surviving controls through the M and W pipeline registers.
//
// Ports:
//   clk    core clock, rising-edge
//   reset  asynchronous active-high clear of E, M, W and NZCV
//   bus    exec_ctrl_pipe_if.slave - decode controls in, staged controls out
// -----------------------------------------------------------------------------
module exec_ctrl_pipe (
  input  logic           clk,
  input  logic           reset,
  exec_ctrl_pipe_if.slave bus
);

  typedef struct packed {
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_control;
    logic [1:0] alu_src;
    logic [1:0] flag_write;
    logic [3:0] cond;
  } ctrl_e_t;

  typedef struct packed {
    logic pc_src;
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } ctrl_m_t;

  typedef struct packed {
    logic pc_src;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_w_t;

  ctrl_e_t    e_q, e_d;
  ctrl_m_t    m_q, m_d;
  ctrl_w_t    w_q, w_d;
  logic [3:0] flags_q, flags_d;

  logic       cond_ex_e;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic [1:0] flag_write_gated;

  // ---------------------------------------------------------------------------
  // Condition evaluation. Always uses the registered flags, so an instruction
  // never sees its own flag update; the next instruction in E does.
  // ---------------------------------------------------------------------------
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_ex_e = 1'b0;
    unique case (e_q.cond)
      4'b0000: cond_ex_e = flag_z;
      4'b0001: cond_ex_e = ~flag_z;
      4'b0010: cond_ex_e = flag_c;
      4'b0011: cond_ex_e = ~flag_c;
      4'b0100: cond_ex_e = flag_n;
      4'b0101: cond_ex_e = ~flag_n;
      4'b0110: cond_ex_e = flag_v;
      4'b0111: cond_ex_e = ~flag_v;
      4'b1000: cond_ex_e = flag_c & ~flag_z;
      4'b1001: cond_ex_e = ~flag_c | flag_z;
      4'b1010: cond_ex_e = (flag_n == flag_v);
      4'b1011: cond_ex_e = (flag_n != flag_v);
      4'b1100: cond_ex_e = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex_e = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex_e = 1'b1;
      4'b1111: cond_ex_e = 1'b0;
      default: cond_ex_e = 1'b0;
    endcase
  end

  assign flag_write_gated = e_q.flag_write & {2{cond_ex_e}};

  // ---------------------------------------------------------------------------
  // Next-state logic for E, NZCV, M and W.
  // ---------------------------------------------------------------------------
  always_comb begin
    // E register: a flush loads an all-zero bubble; every gated control being
    // zero is what makes the bubble side-effect free.
    e_d = '0;
    if (!bus.FlushE) begin
      e_d.pc_src      = bus.PCSrcD;
      e_d.reg_write   = bus.RegWriteD;
      e_d.mem_to_reg  = bus.MemtoRegD;
      e_d.mem_write   = bus.MemWriteD;
      e_d.branch      = bus.BranchD;
      e_d.alu_control = bus.ALUControlD;
      e_d.alu_src     = bus.ALUSrcD;
      e_d.flag_write  = bus.FlagWriteD;
      e_d.cond        = bus.CondD;
    end

    // NZCV: the two halves are written independently, unwritten bits hold.
    flags_d = flags_q;
    if (flag_write_gated[1]) flags_d[3:2] = bus.ALUFlags[3:2];
    if (flag_write_gated[0]) flags_d[1:0] = bus.ALUFlags[1:0];

    // E->M: side-effecting controls are squashed by a failed condition;
    // MemtoReg is passed through ungated since it only steers the W mux.
    m_d.pc_src     = e_q.pc_src    & cond_ex_e;
    m_d.reg_write  = e_q.reg_write & cond_ex_e;
    m_d.mem_write  = e_q.mem_write & cond_ex_e;
    m_d.mem_to_reg = e_q.mem_to_reg;

    // M->W: straight copy.
    w_d.pc_src     = m_q.pc_src;
    w_d.reg_write  = m_q.reg_write;
    w_d.mem_to_reg = m_q.mem_to_reg;
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset clears immediately, independent of clk.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      flags_q <= 4'b0000;
    end else begin
      e_q     <= e_d;
      m_q     <= m_d;
      w_q     <= w_d;
      flags_q <= flags_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------
  assign bus.ALUControlE  = e_q.alu_control;
  assign bus.ALUSrcE      = e_q.alu_src;
  assign bus.MemtoRegE    = e_q.mem_to_reg;
  assign bus.BranchTakenE = e_q.branch & cond_ex_e;

  assign bus.PCSrcM       = m_q.pc_src;
  assign bus.RegWriteM    = m_q.reg_write;
  assign bus.MemtoRegM    = m_q.mem_to_reg;
  assign bus.MemWriteM    = m_q.mem_write;

  assign bus.PCSrcW       = w_q.pc_src;
  assign bus.RegWriteW    = w_q.reg_write;
  assign bus.MemtoRegW    = w_q.mem_to_reg;

  assign bus.FlagsQ       = flags_q;

endmodule

// File: tb/tb_exec_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_exec_ctrl_pipe
// Directed bench for exec_ctrl_pipe: a linear sequence of decode control
// words with hand-computed expected pipeline outputs and NZCV contents.
// -----------------------------------------------------------------------------
module tb_exec_ctrl_pipe;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  exec_ctrl_pipe_if bus_if ();

  exec_ctrl_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every output concatenated, for the all-zero reset checks.
  function automatic logic [16:0] all_out();
    return {bus_if.ALUControlE, bus_if.ALUSrcE, bus_if.MemtoRegE,
            bus_if.BranchTakenE, bus_if.PCSrcM, bus_if.RegWriteM,
            bus_if.MemtoRegM, bus_if.MemWriteM, bus_if.PCSrcW,
            bus_if.RegWriteW, bus_if.MemtoRegW, bus_if.FlagsQ};
  endfunction

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    $display("[TB] check %s observed=%h expected=%h", tag, got, exp);
  endtask

  // Drive one decode control word: pcsrc, regwrite, memtoreg, memwrite,
  // branch, alucontrol, alusrc, flagwrite, cond.
  task automatic drive(input logic ps, input logic rw, input logic mr,
                       input logic mw, input logic br, input logic [1:0] ac,
                       input logic [1:0] as, input logic [1:0] fw,
                       input logic [3:0] cd);
    bus_if.PCSrcD      = ps;
    bus_if.RegWriteD   = rw;
    bus_if.MemtoRegD   = mr;
    bus_if.MemWriteD   = mw;
    bus_if.BranchD     = br;
    bus_if.ALUControlD = ac;
    bus_if.ALUSrcD     = as;
    bus_if.FlagWriteD  = fw;
    bus_if.CondD       = cd;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b1110);
  endtask

  // Advance one edge and settle 1 time unit past it before checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus_if.FlushE   = 1'b0;
    bus_if.ALUFlags = 4'b1111;
    // Nonzero controls during reset must not leak into the pipeline.
    drive(1, 1, 1, 1, 1, 2'b11, 2'b11, 2'b11, 4'b1110);
    tick();
    tick();
    chk("reset_all_zero", all_out(), 17'd0);

    reset = 1'b0;
    nop();
    bus_if.ALUFlags = 4'b0000;
    tick();

    // SUBS in D, then BEQ.
    drive(0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b11, 4'b1110);
    tick();
    chk("subs_alucontrol_e", 17'(bus_if.ALUControlE), 17'b01);
    chk("subs_not_branch", 17'(bus_if.BranchTakenE), 17'd0);
    bus_if.ALUFlags = 4'b0100;
    drive(1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000);
    chk("flags_before_update", 17'(bus_if.FlagsQ), 17'h0);
    tick();
    chk("flags_after_subs", 17'(bus_if.FlagsQ), 17'h4);
    chk("beq_taken", 17'(bus_if.BranchTakenE), 17'd1);
    chk("subs_regwrite_m", 17'(bus_if.RegWriteM), 17'd1);

    // NE with Z=1 fails: regwrite/memwrite/flagwrite all squashed.
    bus_if.ALUFlags = 4'b1111;
    drive(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b11, 4'b0001);
    tick();
    chk("beq_pcsrc_m", 17'(bus_if.PCSrcM), 17'd1);
    // Partial write of N,Z only.
    drive(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 4'b1110);
    tick();
    chk("ne_regwrite_m", 17'(bus_if.RegWriteM), 17'd0);
    chk("ne_memwrite_m", 17'(bus_if.MemWriteM), 17'd0);
    chk("ne_flags_hold", 17'(bus_if.FlagsQ), 17'h4);
    chk("beq_pcsrc_w", 17'(bus_if.PCSrcW), 17'd1);
    nop();
    tick();
    chk("partial_nz_write", 17'(bus_if.FlagsQ), 17'hC);
    // Partial write of C,V only.
    drive(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 4'b1110);
    tick();
    bus_if.ALUFlags = 4'b0010;
    nop();
    tick();
    chk("partial_cv_write", 17'(bus_if.FlagsQ), 17'hE);

    // Flags now N=1 Z=1 C=1 V=0.
    drive(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b1101);
    tick();
    chk("cond_le_taken", 17'(bus_if.BranchTakenE), 17'd1);
    drive(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b1100);
    tick();
    chk("cond_gt_not_taken", 17'(bus_if.BranchTakenE), 17'd0);
    drive(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b1000);
    tick();
    chk("cond_hi_not_taken", 17'(bus_if.BranchTakenE), 17'd0);
    drive(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b1011);
    tick();
    chk("cond_lt_taken", 17'(bus_if.BranchTakenE), 17'd1);

    // Flush: the instruction already in E still advances.
    drive(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b1110);
    tick();
    bus_if.ALUFlags = 4'b0001;
    bus_if.FlushE   = 1'b1;
    drive(0, 1, 0, 0, 1, 2'b11, 2'b10, 2'b11, 4'b1110);
    tick();
    bus_if.FlushE = 1'b0;
    chk("flush_alucontrol_e", 17'(bus_if.ALUControlE), 17'b00);
    chk("flush_alusrc_e", 17'(bus_if.ALUSrcE), 17'b00);
    chk("flush_not_branch", 17'(bus_if.BranchTakenE), 17'd0);
    chk("flush_prev_advances", 17'(bus_if.RegWriteM), 17'd1);
    nop();
    tick();
    chk("flush_regwrite_m", 17'(bus_if.RegWriteM), 17'd0);
    chk("flush_flags_hold", 17'(bus_if.FlagsQ), 17'hE);

    // Load propagation.
    drive(0, 1, 1, 0, 0, 2'b00, 2'b01, 2'b00, 4'b1110);
    tick();
    chk("load_memtoreg_e", 17'(bus_if.MemtoRegE), 17'd1);
    chk("load_alusrc_e", 17'(bus_if.ALUSrcE), 17'b01);
    nop();
    tick();
    chk("load_m", 17'({bus_if.RegWriteM, bus_if.MemtoRegM}), 17'b11);
    tick();
    chk("load_w", 17'({bus_if.RegWriteW, bus_if.MemtoRegW}), 17'b11);
    // Never-executed load: MemtoReg ungated, RegWrite squashed.
    drive(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'b1111);
    tick();
    chk("nv_memtoreg_e", 17'(bus_if.MemtoRegE), 17'd1);
    nop();
    tick();
    chk("nv_m", 17'({bus_if.RegWriteM, bus_if.MemtoRegM}), 17'b01);

    // Asynchronous reset in mid-cycle with a populated pipeline.
    drive(1, 1, 1, 1, 1, 2'b10, 2'b11, 2'b00, 4'b1110);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_all_zero", all_out(), 17'd0);
    tick();
    chk("reset_held_all_zero", all_out(), 17'd0);
    reset = 1'b0;
    drive(0, 1, 1, 0, 0, 2'b11, 2'b00, 2'b00, 4'b1110);
    #1;
    chk("no_load_before_edge", 17'(bus_if.ALUControlE), 17'b00);
    tick();
    chk("first_load_after_reset", 17'(bus_if.ALUControlE), 17'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
